kernel_sysid_checker: RTL
=========================

// Module: kernel_sysid_checker
// PURPOSE
//  Avalon-MM read master; initiator counterpart to the system-ID control slave.
//  After reset (or on start), reads the ID word (addr 0) and the timestamp (addr 1).
//  Compares both words against the build-time expected values.
//  Reports pass/fail to the boot/reset sequencer so a mismatched FPGA image halts CPU release.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  value required at word address 0
//  EXPECTED_TS     32'h5B66_FA79  value required at word address 1
//  AUTO_START      1              1: check launches automatically 1 cycle after reset release
//  RETRY_MAX       2              extra full read passes after a mismatch (0..15)
//  TIMEOUT_CYCLES  1024           waitrequest-stall limit (used only with SYSID_CHK_TIMEOUT_EN)
// PORTS
//  clock         in   1   system clock
//  reset_n       in   1   asynchronous active-low reset
//  start         in   1   pulse: begin check; ignored while busy
//  address       out  1   Avalon word address to sysid slave
//  read          out  1   Avalon read strobe
//  waitrequest   in   1   slave stall; tie 0 for zero-wait slave
//  readdata      in   32  slave read data, valid when read & !waitrequest
//  busy          out  1   check in progress
//  done          out  1   sticky: check finished (pass or fail)
//  pass          out  1   sticky: both words matched
//  id_value      out  32  last captured ID word
//  ts_value      out  32  last captured timestamp word
//  timeout       out  1   sticky: stall limit hit (0 when feature absent)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; retry count 0.
//  Handshake: read/address held stable until the cycle read=1 & waitrequest=0; readdata captured that cycle.
//  Read drops for exactly 1 cycle between accesses; no back-to-back strobes.
//  FSM: IDLE -> RD_ID (start, or AUTO_START on 1st cycle after reset) -> RD_TS -> CMP -> DONE.
//  RD_ID: address=0, read=1; on accept capture id_value.
//  RD_TS: address=1, read=1; on accept capture ts_value.
//  CMP (1 cycle): match both -> DONE with pass=1.
//  CMP mismatch, retries left: increment count, re-enter RD_ID.
//  CMP mismatch, retries exhausted: DONE with pass=0.
//  Latency, zero-wait slave: start at cycle N -> done=1 at N+5 (RD_ID, gap, RD_TS, gap/CMP, DONE).
//  busy=1 in RD_ID..CMP. done/pass/timeout stay set in DONE.
//  start in DONE: clear done/pass/timeout/retry count and re-enter RD_ID next cycle.
//  start while busy: ignored. start coincident with AUTO_START launch: a single check.
//  Async reset mid-transaction: read drops immediately; flags clear; AUTO_START relaunches after release.
// CONFIGURATION
//  SYSID_CHK_TIMEOUT_EN defined: stall counter runs while read=1 & waitrequest=1.
//    Counter clears on each accept.
//    Reaching TIMEOUT_CYCLES: drop read; timeout=1, pass=0, done=1. No retry.
//  SYSID_CHK_TIMEOUT_EN undefined: no counter; master waits indefinitely; timeout tied 0.
// STRUCTURE
//  Package kernel_sysid_pkg holds:
//    state enum (IDLE, RD_ID, RD_TS, CMP, DONE)
//    word address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1
//    32-bit data width constant
//  Sub-module kernel_sysid_stall_timer: the timeout counter; instantiated only under the macro.
//  The FSM and compare logic stay in the top module.
// TESTING
//  Zero-wait slave returning 0 / 0x5B66FA79, AUTO_START=1 -> done=1, pass=1 at 5 cycles after reset release.
//  ID word returns 0x00000001, RETRY_MAX=2 -> 3 passes (6 reads), then done=1, pass=0, id_value=1.
//  waitrequest held 3 cycles on each read -> address/read stable throughout; pass=1 at 11 cycles.
//  Macro defined, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> read drops after 16 cycles; timeout=1, done=1, pass=0.
//  reset_n asserted during RD_TS, then released -> all outputs 0; fresh check completes with pass=1.
//  start pulsed while busy, then again in DONE -> first pulse ignored; second clears flags and runs a new check.

Source files
------------

// File: rtl/kernel_sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   sysid_state_e  : checker FSM states
//   SYSID_ADDR_*   : word addresses of the ID and timestamp registers
//   SYSID_DATA_W   : Avalon data width
package kernel_sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    DONE
  } sysid_state_e;

  // True when both captured words equal their build-time expected values.
  function automatic logic sysid_words_match(
    input logic [SYSID_DATA_W-1:0] id_word,
    input logic [SYSID_DATA_W-1:0] ts_word,
    input logic [SYSID_DATA_W-1:0] exp_id,
    input logic [SYSID_DATA_W-1:0] exp_ts
  );
    return (id_word == exp_id) && (ts_word == exp_ts);
  endfunction

endpackage

// File: rtl/kernel_sysid_stall_timer.sv
// Waitrequest stall timer for the system-ID checker.
// Counts consecutive stalled cycles and flags expiry on the TIMEOUT_CYCLES-th one.
// Only instantiated when SYSID_CHK_TIMEOUT_EN is defined.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   stall    in   read asserted and slave stalling this cycle
//   expired  out  this stalled cycle is the TIMEOUT_CYCLES-th in a row
module kernel_sysid_stall_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any non-stalled cycle (accept, idle, or the drop after expiry) restarts the count.
  always_comb begin
    cnt_d   = '0;
    expired = 1'b0;
    if (stall) begin
      cnt_d   = cnt_q + 1'b1;
      expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kernel_sysid_checker.sv
// System-ID checker: Avalon-MM read master that fetches the ID word (addr 0) and
// build timestamp (addr 1) from the system-ID slave, compares both against build-time
// values and reports pass/fail so a mismatched FPGA image can hold off CPU release.
// Optional feature macro: SYSID_CHK_TIMEOUT_EN (waitrequest stall timeout).
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse: begin a check (ignored while busy)
//   address      out  Avalon word address
//   read         out  Avalon read strobe
//   waitrequest  in   slave stall
//   readdata     in   slave read data
//   busy         out  check in progress
//   done         out  sticky: check finished
//   pass         out  sticky: both words matched
//   id_value     out  last captured ID word
//   ts_value     out  last captured timestamp word
//   timeout      out  sticky: stall limit hit (always 0 without the macro)
module kernel_sysid_checker
  import kernel_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'h5B66_FA79,
  parameter bit                      AUTO_START     = 1'b1,
  parameter int unsigned             RETRY_MAX      = 2,
  parameter int unsigned             TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    address,
  output logic                    read,
  input  logic                    waitrequest,
  input  logic [SYSID_DATA_W-1:0] readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    timeout
);

  sysid_state_e            state_q, state_d;
  logic                    gap_q, gap_d;
  logic                    auto_q, auto_d;
  logic [3:0]              retry_q, retry_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timeout_q, timeout_d;
  logic [SYSID_DATA_W-1:0] id_q, id_d;
  logic [SYSID_DATA_W-1:0] ts_q, ts_d;

  logic accept;
  logic stall_expired;

  // gap_q marks the idle cycle between the ID and timestamp reads; CMP provides the
  // idle cycle after the timestamp read, so strobes are never back-to-back.
  assign read    = ((state_q == RD_ID) || (state_q == RD_TS)) && !gap_q;
  assign address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign accept  = read && !waitrequest;
  assign busy    = (state_q == RD_ID) || (state_q == RD_TS) || (state_q == CMP);

  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

`ifdef SYSID_CHK_TIMEOUT_EN
  kernel_sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .stall  (read && waitrequest),
    .expired(stall_expired)
  );
`else
  // No stall limit: the master waits on waitrequest indefinitely.
  assign stall_expired = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d   = state_q;
    gap_d     = 1'b0;
    auto_d    = 1'b0;  // auto launch is only offered on the first cycle after reset
    retry_d   = retry_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    id_d      = id_q;
    ts_d      = ts_q;

    unique case (state_q)
      IDLE: begin
        // start coincident with auto launch still yields one check
        if (start || auto_q) begin
          state_d = RD_ID;
          retry_d = '0;
        end
      end
      RD_ID: begin
        if (stall_expired) begin
          state_d   = DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (accept) begin
          id_d    = readdata;
          state_d = RD_TS;
          gap_d   = 1'b1;
        end
      end
      RD_TS: begin
        if (stall_expired) begin
          state_d   = DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (accept) begin
          ts_d    = readdata;
          state_d = CMP;
        end
      end
      CMP: begin
        if (sysid_words_match(id_q, ts_q, EXPECTED_ID, EXPECTED_TS)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (retry_q < 4'(RETRY_MAX)) begin
          retry_d = retry_q + 4'd1;
          state_d = RD_ID;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = RD_ID;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          retry_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_q     <= 1'b0;
      auto_q    <= AUTO_START;
      retry_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      auto_q    <= auto_d;
      retry_q   <= retry_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
    end
  end

endmodule
